// File: rtl/request_encoder_32x5_pkg.sv
// Shared widths, FSM states and helpers for the 32-to-5 request encoder.
package request_encoder_32x5_pkg;

    localparam int REQ_W     = 32;
    localparam int IDX_W     = 5;
    localparam int GRP_N     = 4;   // number of 8-bit groups in the encoder tree
    localparam int GRP_W     = 8;   // bits per group
    localparam int GRP_IDX_W = 3;   // index width inside a group
    localparam int GRP_SEL_W = 2;   // group-select index width

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // One-hot mask of an encoded index, used to retire the bit being loaded.
    function automatic logic [REQ_W-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return REQ_W'(1) << idx;
    endfunction

endpackage

// File: rtl/request_encoder_32x5_prio.sv
// Combinational priority encoders: an 8x3 leaf and the 32x5 tree built from
// four leaves plus a 4x2 group select.
module priority_encoder_8x3
    import request_encoder_32x5_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [GRP_W-1:0]     IN,
    output logic [GRP_IDX_W-1:0] OUT,
    output logic                 ANY
);

    // Scan so that the last matching bit written is the one with priority.
    always_comb begin
        OUT = '0;
        ANY = |IN;
        if (LOW_FIRST) begin
            for (int i = GRP_W - 1; i >= 0; i--)
                if (IN[i]) OUT = GRP_IDX_W'(i);
        end else begin
            for (int i = 0; i < GRP_W; i++)
                if (IN[i]) OUT = GRP_IDX_W'(i);
        end
    end

endmodule

module priority_encoder_32x5
    import request_encoder_32x5_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0] IN,
    output logic [IDX_W-1:0] OUT,
    output logic             ANY
);

    logic [GRP_N-1:0][GRP_IDX_W-1:0] sub_idx;
    logic [GRP_N-1:0]                grp_any;
    logic [GRP_SEL_W-1:0]            grp;

    for (genvar g = 0; g < GRP_N; g++) begin : g_grp
        priority_encoder_8x3 #(.LOW_FIRST(LOW_FIRST)) u_enc (
            .IN  (IN[g*GRP_W +: GRP_W]),
            .OUT (sub_idx[g]),
            .ANY (grp_any[g])
        );
    end

    // 4x2 group select: same priority direction as the leaves.
    always_comb begin
        grp = '0;
        if (LOW_FIRST) begin
            for (int i = GRP_N - 1; i >= 0; i--)
                if (grp_any[i]) grp = GRP_SEL_W'(i);
        end else begin
            for (int i = 0; i < GRP_N; i++)
                if (grp_any[i]) grp = GRP_SEL_W'(i);
        end
    end

    assign OUT = {grp, sub_idx[grp]};
    assign ANY = |grp_any;

endmodule

// File: rtl/request_encoder_32x5.sv
// Sequential 32-to-5 request encoder: merges request vectors into a pending
// register and hands out one encoded index per handshake.
module request_encoder_32x5
    import request_encoder_32x5_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic [REQ_W-1:0] REQ_IN,
    input  logic             REQ_VALID,
    input  logic             CLEAR,
    output logic [IDX_W-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             PENDING
);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] out_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             handshake;
    logic             load;

    // Selection looks only at the registered pending bits, so a request
    // merged this edge becomes selectable one edge later.
    priority_encoder_32x5 #(.LOW_FIRST(LOW_FIRST)) u_prio (
        .IN  (pend_q),
        .OUT (enc_idx),
        .ANY (enc_any)
    );

    assign handshake = (state_q == ST_PRESENT) && OUT_READY;
    assign load      = EN && enc_any && ((state_q == ST_IDLE) || handshake);

    // Next state: load moves/keeps PRESENT, an unrefilled handshake drops to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (load) state_d = ST_PRESENT;
            ST_PRESENT: if (handshake && !load) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Merge: retire the loaded bit, then OR new requests so a re-raise wins.
    always_comb begin
        pend_d = pend_q & ~(load ? idx_onehot(enc_idx) : '0);
        if (REQ_VALID) pend_d = pend_d | REQ_IN;
    end

    // State, pending and output registers; reset and flush clear everything.
    always_ff @(posedge CLK) begin
        if (!RESET_N || CLEAR) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (load) out_q <= enc_idx;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = (state_q == ST_PRESENT);
    assign PENDING   = |pend_q;

endmodule
